// File: rtl/sound_pkg.sv
// ---------------------------------------------------------------------------
// sound_pkg
// Shared definitions for the sound scheduler slice:
//   - requester index constants (one requester per game event)
//   - default per-sample playback durations, in duration ticks
//   - scheduler state encoding
// No ports; imported by sound_scheduler and its testbench.
// ---------------------------------------------------------------------------
package sound_pkg;

  // Requester i plays sample i; a lower index means a higher priority.
  localparam int REQ_PADDLE = 0;
  localparam int REQ_BRICK  = 1;
  localparam int REQ_WALL   = 2;
  localparam int REQ_LOST   = 3;

  localparam int DEFAULT_REQ_COUNT = 4;
  localparam int DEFAULT_DUR_BITS  = 10;

  // Playback length of each sample in ticks (1 ms per tick at the default
  // prescaler setting). Index = sample number = requester number.
  localparam logic [DEFAULT_DUR_BITS-1:0] SAMPLE_DUR [DEFAULT_REQ_COUNT] =
    '{10'd60, 10'd40, 10'd30, 10'd500};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    FIRE    = 2'd2,
    PLAYING = 2'd3
  } sched_state_e;

endpackage

// File: rtl/sound_scheduler_if.sv
// ---------------------------------------------------------------------------
// sound_scheduler_if
// Bundles the game-event request bus and the sample-bank control signals.
//   REQ     : one-cycle request pulses from game logic, bit 0 highest priority
//   SELECT  : sample index presented to the sample bank
//   TRIGGER : one-cycle start pulse to the sample bank
//   BUSY    : channel occupied (arming, firing or playing)
//   PENDING : latched, not-yet-granted requests (debug / LEDs)
// Modports:
//   master : game-logic side (drives REQ, observes the rest)
//   slave  : scheduler side (consumes REQ, drives the rest)
// ---------------------------------------------------------------------------
interface sound_scheduler_if #(
  parameter int REQ_COUNT   = 4,
  parameter int SAMPLE_BITS = 2
);

  logic [REQ_COUNT-1:0]   REQ;
  logic [SAMPLE_BITS-1:0] SELECT;
  logic                   TRIGGER;
  logic                   BUSY;
  logic [REQ_COUNT-1:0]   PENDING;

  modport master (
    output REQ,
    input  SELECT,
    input  TRIGGER,
    input  BUSY,
    input  PENDING
  );

  modport slave (
    input  REQ,
    output SELECT,
    output TRIGGER,
    output BUSY,
    output PENDING
  );

endinterface

// File: rtl/tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
// Prescaler that counts 0..TICK_DIV-1 while enabled and emits a one-cycle
// tick on the cycle the count wraps. A synchronous clear restarts it at 0 so
// every playback begins with a full tick period.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   clr  : synchronous clear, dominates enable
//   en   : count enable
//   tick : high for the single cycle in which the count wraps
// ---------------------------------------------------------------------------
module tick_divider #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_BITS = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TICK_DIV - 1);

  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;
  logic                wrap;

  always_comb begin
    wrap  = en && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  // A clear in the same cycle as a wrap cancels the tick.
  assign tick = wrap && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sound_scheduler.sv
// ---------------------------------------------------------------------------
// sound_scheduler
// Shares the single sample-bank playback channel between game-event
// requesters. One-cycle request pulses are latched as pending flags; when the
// channel is idle the lowest-index pending flag is granted. The scheduler
// then presents SELECT (ARM), pulses TRIGGER for one cycle (FIRE), and holds
// the channel for the sample's duration in ticks (PLAYING) before returning
// to IDLE for exactly one cycle.
//
// Ports:
//   CLK   : system clock
//   RESET : asynchronous active-high reset; aborts any playback in progress
//   bus   : sound_scheduler_if slave modport (REQ in; SELECT, TRIGGER,
//           BUSY, PENDING out; all outputs registered)
//
// Parameters:
//   REQ_COUNT   : number of requesters (requester i plays sample i)
//   SAMPLE_BITS : width of SELECT, 2**SAMPLE_BITS >= REQ_COUNT
//   TICK_DIV    : clock cycles per duration tick
//   DUR_BITS    : width of the duration counter
//   DUR_TABLE   : ticks per sample index (defaults to sound_pkg::SAMPLE_DUR)
//
// Configuration macro:
//   SOUND_SCHEDULER_PREEMPT_EN : when defined, a pending request of strictly
//   higher priority (lower index) than the one playing interrupts it and is
//   armed immediately; the interrupted sample is dropped. When undefined,
//   every playback runs to completion.
// ---------------------------------------------------------------------------
module sound_scheduler
  import sound_pkg::*;
#(
  parameter int REQ_COUNT   = 4,
  parameter int SAMPLE_BITS = 2,
  parameter int TICK_DIV    = 50000,
  parameter int DUR_BITS    = 10,
  parameter logic [DUR_BITS-1:0] DUR_TABLE [REQ_COUNT] = SAMPLE_DUR
) (
  input  logic                CLK,
  input  logic                RESET,
  sound_scheduler_if.slave    bus
);

  sched_state_e           state_q;
  sched_state_e           state_d;
  logic [REQ_COUNT-1:0]   pend_q;
  logic [REQ_COUNT-1:0]   pend_d;
  logic [SAMPLE_BITS-1:0] sel_q;
  logic [SAMPLE_BITS-1:0] sel_d;
  logic                   trig_q;
  logic                   trig_d;
  logic                   busy_q;
  logic                   busy_d;
  logic [DUR_BITS-1:0]    dur_q;
  logic [DUR_BITS-1:0]    dur_d;

  logic [REQ_COUNT-1:0]   arm_clear;
  logic [SAMPLE_BITS-1:0] top_idx;
  logic                   any_pend;
  logic                   preempt;
  logic                   playing;
  logic                   tick;

  // The prescaler only runs while a sample is playing and sits cleared
  // otherwise, so each playback starts with a full tick period.
  assign playing = (state_q == PLAYING);

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk  (CLK),
    .rst  (RESET),
    .clr  (!playing),
    .en   (playing),
    .tick (tick)
  );

  // Priority encoder: index of the lowest set pending flag. Scanning from
  // the top down lets the lowest index overwrite any higher one.
  always_comb begin
    top_idx = '0;
    for (int i = REQ_COUNT - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        top_idx = SAMPLE_BITS'(i);
      end
    end
  end

  assign any_pend = |pend_q;

`ifdef SOUND_SCHEDULER_PREEMPT_EN
  // Only a strictly higher-priority request may interrupt; because top_idx
  // is the best pending index, comparing it against SELECT is sufficient.
  assign preempt = playing && any_pend && (top_idx < sel_q);
`else
  assign preempt = 1'b0;
`endif

  // Next-state logic. Granting a request clears its flag on the edge that
  // enters ARM; a new pulse for the same index on that edge re-sets it
  // because the request OR is applied after the clear.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    dur_d     = dur_q;
    arm_clear = '0;

    case (state_q)
      IDLE: begin
        if (any_pend) begin
          state_d   = ARM;
          sel_d     = top_idx;
          arm_clear = REQ_COUNT'(1) << top_idx;
        end
      end

      ARM: begin
        state_d = FIRE;
      end

      FIRE: begin
        state_d = PLAYING;
        dur_d   = DUR_TABLE[sel_q];
      end

      PLAYING: begin
        if (preempt) begin
          state_d   = ARM;
          sel_d     = top_idx;
          arm_clear = REQ_COUNT'(1) << top_idx;
        end else if (dur_q == '0) begin
          // Zero-length sample: release the channel straight away.
          state_d = IDLE;
        end else if (tick) begin
          // The counter holds the remaining ticks; the playback ends on the
          // tick that takes it to zero, so it never decrements below zero.
          dur_d = dur_q - DUR_BITS'(1);
          if (dur_q == DUR_BITS'(1)) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    pend_d = (pend_q & ~arm_clear) | bus.REQ;
    trig_d = (state_d == FIRE);
    busy_d = (state_d != IDLE);
  end

  // All scheduler state and every output is registered here.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      pend_q  <= '0;
      sel_q   <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      dur_q   <= dur_d;
    end
  end

  assign bus.SELECT  = sel_q;
  assign bus.TRIGGER = trig_q;
  assign bus.BUSY    = busy_q;
  assign bus.PENDING = pend_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sound_scheduler
// Exercises sound_scheduler with TICK_DIV=4 and sample durations {3,2,1,0}.
// The reference model is a timeline of playbacks: a grant decided in an idle
// cycle arms on the next edge, fires one edge later, and releases the channel
// a fixed number of edges after arming, computed from the duration table.
// Honours SOUND_SCHEDULER_PREEMPT_EN when the build defines it.
// ---------------------------------------------------------------------------
module tb_sound_scheduler;
  import sound_pkg::*;

  localparam int TD = 4;
  localparam int DUR [4] = '{3, 2, 1, 0};

  logic CLK = 1'b0;
  logic RESET;

  int total;
  int bad;

  sound_scheduler_if #(.REQ_COUNT(4), .SAMPLE_BITS(2)) bus ();

  sound_scheduler #(
    .REQ_COUNT   (4),
    .SAMPLE_BITS (2),
    .TICK_DIV    (TD),
    .DUR_BITS    (10),
    .DUR_TABLE   ('{10'd3, 10'd2, 10'd1, 10'd0})
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Reference model state, valid just after each clock edge.
  int         edge_n;
  logic [3:0] m_pend;
  int         m_sel;
  logic       m_active;
  logic       m_trig;
  int         m_cur;
  int         m_arm;
  int         m_done;

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return 4;
  endfunction

  task automatic model_reset();
    edge_n   = 0;
    m_pend   = '0;
    m_sel    = 0;
    m_active = 1'b0;
    m_trig   = 1'b0;
    m_cur    = 0;
    m_arm    = -100;
    m_done   = -100;
  endtask

  // Advance the model across one edge at which request vector r is sampled.
  task automatic model_edge(input logic [3:0] r);
    logic grant;
    int   g;
    edge_n++;
    g     = lowest(m_pend);
    grant = 1'b0;
    if (!m_active && (m_pend != 4'b0)) begin
      grant = 1'b1;
    end
`ifdef SOUND_SCHEDULER_PREEMPT_EN
    else if (m_active && ((edge_n - 1) >= m_arm + 2) && (g < m_cur)) begin
      grant = 1'b1;
    end
`endif
    if (grant) begin
      m_cur     = g;
      m_sel     = g;
      m_arm     = edge_n;
      m_done    = edge_n + 2 + ((DUR[g] == 0) ? 1 : DUR[g] * TD);
      m_pend[g] = 1'b0;
    end
    m_pend   = m_pend | r;
    m_active = grant || (m_active && (edge_n < m_done));
    m_trig   = m_active && (edge_n == m_arm + 1);
  endtask

  function automatic logic [7:0] vec_got();
    return {bus.SELECT, bus.TRIGGER, bus.BUSY, bus.PENDING};
  endfunction

  function automatic logic [7:0] vec_exp();
    logic [31:0] s;
    s = m_sel;
    return {s[1:0], m_trig, m_active, m_pend};
  endfunction

  // Present r for one edge, update the model, then sample 1 time unit later.
  task automatic step(input logic [3:0] r);
    bus.REQ = r;
    @(posedge CLK);
    model_edge(r);
    #1;
    bus.REQ = '0;
  endtask

  task automatic test_reset();
    RESET   = 1'b1;
    bus.REQ = '0;
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if (vec_got() !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_hold got=%h want=%h", vec_got(), 8'h00);
    end
    RESET = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step(4'b0000);
      total++;
      if (vec_got() !== vec_exp()) begin
        bad++;
        $display("[TB] FAIL reset_idle step%0d got=%h want=%h", k, vec_got(), vec_exp());
      end
    end
  endtask

  task automatic test_single();
    int trig_at;
    int fall_at;
    trig_at = -1;
    fall_at = -1;
    for (int k = 0; k < 16; k++) begin
      step((k == 0) ? 4'(1 << REQ_BRICK) : 4'b0000);
      total++;
      if (vec_got() !== vec_exp()) begin
        bad++;
        $display("[TB] FAIL single step%0d got=%h want=%h", k, vec_got(), vec_exp());
      end
      if ((bus.TRIGGER === 1'b1) && (trig_at < 0)) trig_at = k;
      if ((trig_at >= 0) && (bus.BUSY === 1'b0) && (fall_at < 0)) fall_at = k;
    end
    // Edge k=0 samples REQ; ARM at k=1, FIRE visible after k=2, then
    // DUR[1] ticks of TD clocks starting one edge after FIRE.
    total++;
    if (trig_at !== 2) begin
      bad++;
      $display("[TB] FAIL single_latency got=%0d want=%0d", trig_at, 2);
    end
    total++;
    if (fall_at !== 3 + DUR[REQ_BRICK] * TD) begin
      bad++;
      $display("[TB] FAIL single_duration got=%0d want=%0d", fall_at, 3 + DUR[REQ_BRICK] * TD);
    end
  endtask

  task automatic test_simultaneous();
    int         n_trig;
    int         idle_gap;
    logic [1:0] order [2];
    n_trig   = 0;
    idle_gap = 0;
    order[0] = 2'd0;
    order[1] = 2'd0;
    for (int k = 0; k < 24; k++) begin
      step((k == 0) ? 4'b1010 : 4'b0000);
      total++;
      if (vec_got() !== vec_exp()) begin
        bad++;
        $display("[TB] FAIL simul step%0d got=%h want=%h", k, vec_got(), vec_exp());
      end
      if (bus.TRIGGER === 1'b1) begin
        if (n_trig < 2) order[n_trig] = bus.SELECT;
        n_trig++;
      end else if ((n_trig == 1) && (bus.BUSY === 1'b0)) begin
        idle_gap++;
      end
    end
    total++;
    if ((n_trig !== 2) || (order[0] !== 2'd1) || (order[1] !== 2'd3)) begin
      bad++;
      $display("[TB] FAIL simul_order got n=%0d first=%0d second=%0d want n=2 first=1 second=3",
               n_trig, order[0], order[1]);
    end
    total++;
    if (idle_gap !== 1) begin
      bad++;
      $display("[TB] FAIL simul_idle_gap got=%0d want=1", idle_gap);
    end
  endtask

  task automatic test_coalesce();
    int         n2;
    logic [3:0] r;
    n2 = 0;
    for (int k = 0; k < 32; k++) begin
      r = 4'b0000;
      if (k == 0) r = 4'(1 << REQ_PADDLE);
      if ((k == 4) || (k == 6) || (k == 9)) r = 4'(1 << REQ_WALL);
      step(r);
      total++;
      if (vec_got() !== vec_exp()) begin
        bad++;
        $display("[TB] FAIL coalesce step%0d got=%h want=%h", k, vec_got(), vec_exp());
      end
      if ((bus.TRIGGER === 1'b1) && (bus.SELECT === 2'd2)) n2++;
    end
    total++;
    if (n2 !== 1) begin
      bad++;
      $display("[TB] FAIL coalesce_count got=%0d want=1", n2);
    end
  endtask

  task automatic test_zero_dur();
    int   trig_at;
    logic bsy [12];
    trig_at = -1;
    for (int k = 0; k < 12; k++) begin
      step((k == 0) ? 4'(1 << REQ_LOST) : 4'b0000);
      total++;
      if (vec_got() !== vec_exp()) begin
        bad++;
        $display("[TB] FAIL zero_dur step%0d got=%h want=%h", k, vec_got(), vec_exp());
      end
      bsy[k] = bus.BUSY;
      if ((bus.TRIGGER === 1'b1) && (trig_at < 0)) trig_at = k;
    end
    total++;
    if ((trig_at < 0) || (trig_at > 9)) begin
      bad++;
      $display("[TB] FAIL zero_dur_trigger got=%0d want=2", trig_at);
    end else if ((bsy[trig_at + 1] !== 1'b1) || (bsy[trig_at + 2] !== 1'b0)) begin
      bad++;
      $display("[TB] FAIL zero_dur_busy got=%b%b want=10", bsy[trig_at + 1], bsy[trig_at + 2]);
    end
  endtask

  task automatic test_preempt();
    int n2;
    int s0;
    int fall2;
    n2    = 0;
    s0    = -1;
    fall2 = -1;
    for (int k = 0; k < 32; k++) begin
      // Sample 2 fires after edge 2 and is playing from edge 3, when the
      // paddle request arrives.
      step((k == 0) ? 4'(1 << REQ_WALL) : ((k == 3) ? 4'(1 << REQ_PADDLE) : 4'b0000));
      total++;
      if (vec_got() !== vec_exp()) begin
        bad++;
        $display("[TB] FAIL preempt step%0d got=%h want=%h", k, vec_got(), vec_exp());
      end
      if ((bus.TRIGGER === 1'b1) && (bus.SELECT === 2'd2)) n2++;
      if ((bus.TRIGGER === 1'b1) && (bus.SELECT === 2'd0) && (s0 < 0)) s0 = k;
      if ((n2 > 0) && (s0 < 0) && (bus.BUSY === 1'b0) && (fall2 < 0)) fall2 = k;
    end
    total++;
    if (n2 !== 1) begin
      bad++;
      $display("[TB] FAIL preempt_replay got=%0d want=1", n2);
    end
    total++;
`ifdef SOUND_SCHEDULER_PREEMPT_EN
    if ((s0 < 0) || (s0 - 3 > 3)) begin
      bad++;
      $display("[TB] FAIL preempt_latency got=%0d want<=%0d", s0 - 3, 3);
    end
`else
    if ((fall2 < 0) || (s0 !== fall2 + 2)) begin
      bad++;
      $display("[TB] FAIL preempt_wait got=%0d want=%0d", s0, fall2 + 2);
    end
`endif
  endtask

  task automatic test_back_to_back_random();
    logic [3:0] r;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) begin
        r[i] = ($urandom_range(0, 5) == 0);
      end
      step(r);
      total++;
      if (vec_got() !== vec_exp()) begin
        bad++;
        $display("[TB] FAIL random step%0d req=%b got=%h want=%h", k, r, vec_got(), vec_exp());
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_trig;
    int seen;
    // Let the random traffic drain first.
    for (int k = 0; (k < 200) && (m_active || (m_pend != 4'b0)); k++) begin
      step(4'b0000);
      total++;
      if (vec_got() !== vec_exp()) begin
        bad++;
        $display("[TB] FAIL drain step%0d got=%h want=%h", k, vec_got(), vec_exp());
      end
    end
    seen = -1;
    for (int k = 0; (k < 12) && ((seen < 0) || (k < seen + 3)); k++) begin
      step((k == 0) ? 4'(1 << REQ_WALL) : 4'b0000);
      total++;
      if (vec_got() !== vec_exp()) begin
        bad++;
        $display("[TB] FAIL reset_mid step%0d got=%h want=%h", k, vec_got(), vec_exp());
      end
      if ((bus.TRIGGER === 1'b1) && (seen < 0)) seen = k;
    end
    RESET = 1'b1;
    #2;
    total++;
    if (vec_got() !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_abort got=%h want=%h", vec_got(), 8'h00);
    end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
    n_trig = 0;
    for (int k = 0; k < 10; k++) begin
      step(4'b0000);
      total++;
      if (vec_got() !== vec_exp()) begin
        bad++;
        $display("[TB] FAIL reset_release step%0d got=%h want=%h", k, vec_got(), vec_exp());
      end
      if (bus.TRIGGER !== 1'b0) n_trig++;
    end
    total++;
    if (n_trig !== 0) begin
      bad++;
      $display("[TB] FAIL reset_no_trigger got=%0d want=0", n_trig);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the test sequence finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    RESET   = 1'b1;
    bus.REQ = '0;
    model_reset();
    test_reset();
    test_single();
    test_simultaneous();
    test_coalesce();
    test_zero_dur();
    test_preempt();
    test_back_to_back_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
